sm4_key_expand: RTL and testbench

Iterative SM4 key-schedule engine. It takes a 128-bit master key and produces the 32 round keys rk0..rk31, one per cycle, in encryption order. It sits directly upstream of the round datapath's one-cycle pipeline registers and obeys the same `stall` hold semantics, so both stages freeze together.

---
 rtl/sm4_key_expand_pkg.sv | 55 +++++
 rtl/sm4_key_expand_if.sv | 27 ++
 rtl/sm4_key_expand_sbox.sv | 13 +
 rtl/sm4_key_expand.sv | 122 ++++++++++++
 tb/tb_sm4_key_expand.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sm4_key_expand_pkg.sv
// sm4_pkg: shared constants and types for the SM4 key-schedule engine.
//   - ST_IDLE / ST_RUN FSM encodings
//   - FK system parameters and the 32-entry CK table
//   - the 8-bit S-box table (also used by the round datapath)
//   - L' rotate amounts and a 32-bit rotate helper
package sm4_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int L_ROT_A = 13;
  localparam int L_ROT_B = 23;

  localparam logic [31:0] FK [4] = '{
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  // CK(i) byte j = ((4i+j)*7) mod 256, MSB first
  localparam logic [31:0] CK_TABLE [32] = '{
    32'h00070E15, 32'h1C232A31, 32'h383F464D, 32'h545B6269,
    32'h70777E85, 32'h8C939AA1, 32'hA8AFB6BD, 32'hC4CBD2D9,
    32'hE0E7EEF5, 32'hFC030A11, 32'h181F262D, 32'h343B4249,
    32'h50575E65, 32'h6C737A81, 32'h888F969D, 32'hA4ABB2B9,
    32'hC0C7CED5, 32'hDCE3EAF1, 32'hF8FF060D, 32'h141B2229,
    32'h30373E45, 32'h4C535A61, 32'h686F767D, 32'h848B9299,
    32'hA0A7AEB5, 32'hBCC3CAD1, 32'hD8DFE6ED, 32'hF4FB0209,
    32'h10171E25, 32'h2C333A41, 32'h484F565D, 32'h646B7279
  };

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sm4_key_expand_if.sv
// sm4_key_expand_if: control and round-key bus of the SM4 key-schedule engine.
//   master (driver)  : stall, start, key_in
//   slave  (engine)  : rk_out, rk_idx, rk_valid, busy, done
interface sm4_key_expand_if #(
  parameter int WIDTH = 32
) ();

  logic             stall;
  logic             start;
  logic [127:0]     key_in;
  logic [WIDTH-1:0] rk_out;
  logic [4:0]       rk_idx;
  logic             rk_valid;
  logic             busy;
  logic             done;

  modport master (
    output stall, start, key_in,
    input  rk_out, rk_idx, rk_valid, busy, done
  );

  modport slave (
    input  stall, start, key_in,
    output rk_out, rk_idx, rk_valid, busy, done
  );

endinterface

// File: rtl/sm4_key_expand_sbox.sv
// sm4_sbox: 8-bit combinational SM4 S-box lookup.
//   din  in  8  byte to substitute
//   dout out 8  substituted byte
module sm4_sbox
  import sm4_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX_TABLE[din];

endmodule

// File: rtl/sm4_key_expand.sv
// sm4_key_expand: iterative SM4 key schedule, one round key per cycle.
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset (wins over stall)
//   bus   slave modport of sm4_key_expand_if:
//         stall/start/key_in in; rk_out/rk_idx/rk_valid/busy/done out
// Build option: define SM4_CK_COMPUTE_EN to generate CK(i) arithmetically
// from the step counter instead of reading the package table.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; K window holds the last run (or zeros)
// ST_RUN  | one new round key per non-stalled edge, cnt = step index
module sm4_key_expand
  import sm4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  sm4_key_expand_if.slave bus
);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0][31:0]  k_q, k_d;       // k_q[0] is the oldest word K(i)
  logic [WIDTH-1:0]  rk_out_q, rk_out_d;
  logic [4:0]        rk_idx_q, rk_idx_d;
  logic              rk_valid_q, rk_valid_d;
  logic              done_q, done_d;

  logic [31:0]       ck;
  logic [31:0]       mix;
  logic [31:0]       tau_out;
  logic [31:0]       lin;
  logic [31:0]       new_word;

`ifdef SM4_CK_COMPUTE_EN
  // byte j = (4*cnt + j) * 7, wrapping at 8 bits
  always_comb begin
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      ck[31-8*j -: 8] = 8'(({1'b0, cnt_q, 2'b00} + 8'(j)) * 8'd7);
    end
  end
`else
  assign ck = CK_TABLE[cnt_q];
`endif

  assign mix = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck;

  for (genvar g = 0; g < 4; g++) begin : g_tau
    sm4_sbox u_sbox (
      .din  (mix[8*g +: 8]),
      .dout (tau_out[8*g +: 8])
    );
  end

  assign lin      = tau_out ^ rotl32(tau_out, L_ROT_A) ^ rotl32(tau_out, L_ROT_B);
  assign new_word = k_q[0] ^ lin;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          k_d = {bus.key_in[31:0]   ^ FK[3],
                 bus.key_in[63:32]  ^ FK[2],
                 bus.key_in[95:64]  ^ FK[1],
                 bus.key_in[127:96] ^ FK[0]};
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        k_d        = {new_word, k_q[3], k_q[2], k_q[1]};
        cnt_d      = cnt_q + 5'd1;
        rk_out_d   = new_word;
        rk_idx_d   = cnt_q;
        rk_valid_d = 1'b1;
        if (cnt_q == 5'd31) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // stall freezes every register, including the one-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (!bus.stall) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign bus.rk_out   = rk_out_q;
  assign bus.rk_idx   = rk_idx_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q == ST_RUN);

endmodule

// File: tb/tb_sm4_key_expand.sv
module tb_sm4_key_expand;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };
  localparam logic [31:0]  FK_REF [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
  localparam logic [127:0] REF_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sm4_key_expand_if #(.WIDTH(32)) bus ();

  sm4_key_expand #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] key;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  logic last_rst = 1'b1;
  logic last_stall = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference key schedule: full 36-word K array, pushed as 32 expected keys.
  task automatic push_model(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ck, x, t, l;
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ FK_REF[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
      t = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
      l = t ^ ((t << 13) | (t >> 19)) ^ ((t << 23) | (t >> 9));
      k[i+4] = k[i] ^ l;
      exp_q.push_back('{idx: 5'(i), key: k[i+4]});
    end
  endtask

  always @(posedge clk) begin
    last_rst   = rst;
    last_stall = bus.stall;
  end

  // Monitor: every key-producing edge must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!last_rst && !last_stall && bus.rk_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_key: got idx %0d key %h, expected none", bus.rk_idx, bus.rk_out);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.rk_out, bus.rk_idx, bus.done, bus.busy} !==
            {mon_e.key, mon_e.idx, (mon_e.idx == 5'd31), (mon_e.idx != 5'd31)}) begin
          miscompares++;
          $display("FAIL round_key: got key %h idx %0d done %b busy %b, expected key %h idx %0d done %b busy %b",
                   bus.rk_out, bus.rk_idx, bus.done, bus.busy,
                   mon_e.key, mon_e.idx, (mon_e.idx == 5'd31), (mon_e.idx != 5'd31));
        end
      end
    end
  end

  task automatic do_run(input logic [127:0] key, input int stall_idx, input int stall_len,
                        input int ign_idx, input bit rnd,
                        output int cyc, output int first_cyc,
                        output logic [31:0] rk0, output logic [31:0] rk_last);
    int          stall_left;
    bit          stall_used, ign_used;
    logic [39:0] snap;
    logic        was_stall;
    stall_left = 0; stall_used = 0; ign_used = 0;
    first_cyc = -1; rk0 = '0;
    push_model(key);
    bus.key_in = key;
    bus.stall  = 1'b0;
    bus.start  = 1'b1;
    tick();
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 300) begin
      bus.start = 1'b0;
      if (rnd) begin
        bus.stall = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) begin
          bus.start  = 1'b1;
          bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end else begin
        if (!stall_used && bus.rk_valid === 1'b1 && int'(bus.rk_idx) == stall_idx) begin
          stall_left = stall_len;
          stall_used = 1;
        end
        bus.stall = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        if (!ign_used && bus.rk_valid === 1'b1 && int'(bus.rk_idx) == ign_idx) begin
          bus.start  = 1'b1;
          bus.key_in = ~key;
          ign_used   = 1;
        end
      end
      snap      = {bus.rk_out, bus.rk_idx, bus.rk_valid, bus.done, bus.busy};
      was_stall = bus.stall;
      tick();
      cyc++;
      if (was_stall)
        chk("stall_hold", 64'(snap), 64'({bus.rk_out, bus.rk_idx, bus.rk_valid, bus.done, bus.busy}));
      if (first_cyc < 0 && bus.rk_valid === 1'b1 && bus.rk_idx == 5'd0) begin
        first_cyc = cyc;
        rk0       = bus.rk_out;
      end
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
    chk("run_reaches_done", 64'(bus.done), 64'(1));
    rk_last = bus.rk_out;
  endtask

  initial begin
    int          cyc, fc, cnt;
    logic [31:0] r0, rl;
    bus.stall  = 1'b0;
    bus.start  = 1'b0;
    bus.key_in = '0;
    rst        = 1'b1;
    repeat (3) tick();
    chk("rst_rk_out",   64'(bus.rk_out),   64'(0));
    chk("rst_rk_idx",   64'(bus.rk_idx),   64'(0));
    chk("rst_rk_valid", 64'(bus.rk_valid), 64'(0));
    chk("rst_done",     64'(bus.done),     64'(0));
    chk("rst_busy",     64'(bus.busy),     64'(0));
    rst = 1'b0;
    tick();

    // reference key, no stall
    do_run(REF_KEY, -1, 0, -1, 0, cyc, fc, r0, rl);
    chk("ref_rk0",         64'(r0),       64'(32'hF12186F9));
    chk("ref_rk0_latency", 64'(fc),       64'(1));
    chk("ref_rk31",        64'(rl),       64'(32'h9124A012));
    chk("ref_run_cycles",  64'(cyc),      64'(32));
    chk("ref_busy_at_done", 64'(bus.busy), 64'(0));

    // back-to-back: start in the cycle after done, all-zero key
    do_run(128'h0, -1, 0, -1, 0, cyc, fc, r0, rl);
    chk("b2b_first_latency", 64'(fc),  64'(1));
    chk("b2b_run_cycles",    64'(cyc), 64'(32));
    tick(); tick();

    // stall for 3 cycles while rk_idx is 5
    do_run(REF_KEY, 5, 3, -1, 0, cyc, fc, r0, rl);
    chk("stall_run_cycles", 64'(cyc), 64'(35));
    chk("stall_rk31",       64'(rl),  64'(32'h9124A012));
    tick();

    // start with another key at rk_idx 15 must be ignored
    do_run(REF_KEY, -1, 0, 15, 0, cyc, fc, r0, rl);
    chk("ign_rk31",       64'(rl),  64'(32'h9124A012));
    chk("ign_run_cycles", 64'(cyc), 64'(32));
    tick();

    // reset mid-run
    @(negedge clk); #1;
    chk("queue_drained_pre_rst", 64'(exp_q.size()), 64'(0));
    push_model(REF_KEY);
    bus.key_in = REF_KEY;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    cnt = 0;
    while (!(bus.rk_valid === 1'b1 && bus.rk_idx == 5'd10) && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("reach_idx10_cycles", 64'(cnt), 64'(11));
    rst = 1'b1;
    tick();
    chk("midrun_rst_outputs", 64'({bus.rk_out, bus.rk_idx, bus.rk_valid, bus.done, bus.busy}), 64'(0));
    rst = 1'b0;
    exp_q.delete();
    cnt = 0;
    repeat (40) begin
      tick();
      if (bus.rk_valid === 1'b1 || bus.busy === 1'b1) cnt++;
    end
    chk("quiet_after_rst", 64'(cnt), 64'(0));

    // stalled start in IDLE is not accepted
    bus.stall  = 1'b1;
    bus.start  = 1'b1;
    bus.key_in = REF_KEY;
    tick();
    chk("stalled_start_busy", 64'(bus.busy), 64'(0));
    bus.stall = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("stalled_start_no_load", 64'({bus.busy, bus.rk_valid}), 64'(0));
    tick();

    // randomized keys, random stalls, random ignored starts
    for (int r = 0; r < 8; r++) begin
      do_run({$urandom(), $urandom(), $urandom(), $urandom()}, -1, 0, -1, 1, cyc, fc, r0, rl);
      chk("rnd_done_idx", 64'(bus.rk_idx), 64'(31));
      if (r % 2 == 1) repeat ($urandom_range(1, 4)) tick();
    end

    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
